// File: rtl/ascon_perm_core.sv
// Iterative ASCON permutation p^n (n = 1..MAX_ROUNDS) on a 320-bit state,
// UNROLL rounds per clock, with start/done handshake and argument checking.
module ascon_perm_core #(
  parameter int unsigned UNROLL     = 1,
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         valid_o,
  output logic         error_o
);

  localparam int unsigned STATE_W = 320;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [0:0] {IDLE, RUN} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] st_q, st_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic [STATE_W-1:0] rnd_out;
  logic               legal_c;

  function automatic logic [4:0] sbox(input logic [4:0] v);
    logic [4:0] r;
    case (v)
      5'h00: r = 5'h04;  5'h01: r = 5'h0B;  5'h02: r = 5'h1F;  5'h03: r = 5'h14;
      5'h04: r = 5'h1A;  5'h05: r = 5'h15;  5'h06: r = 5'h09;  5'h07: r = 5'h02;
      5'h08: r = 5'h1B;  5'h09: r = 5'h05;  5'h0A: r = 5'h08;  5'h0B: r = 5'h12;
      5'h0C: r = 5'h1D;  5'h0D: r = 5'h03;  5'h0E: r = 5'h06;  5'h0F: r = 5'h1C;
      5'h10: r = 5'h1E;  5'h11: r = 5'h13;  5'h12: r = 5'h07;  5'h13: r = 5'h0E;
      5'h14: r = 5'h00;  5'h15: r = 5'h0D;  5'h16: r = 5'h11;  5'h17: r = 5'h18;
      5'h18: r = 5'h10;  5'h19: r = 5'h0C;  5'h1A: r = 5'h01;  5'h1B: r = 5'h19;
      5'h1C: r = 5'h16;  5'h1D: r = 5'h0A;  5'h1E: r = 5'h0F;  default: r = 5'h17;
    endcase
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  // One full round: constant addition, column S-box, linear diffusion.
  function automatic logic [STATE_W-1:0] ascon_round(input logic [STATE_W-1:0] s,
                                                     input logic [CNT_W-1:0] idx);
    logic [WORD_W-1:0] x0, x1, x2, x3, x4;
    logic [WORD_W-1:0] t0, t1, t2, t3, t4;
    logic [4:0]        col;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2[7:0] = x2[7:0] ^ {4'd15 - idx, idx};
    for (int k = 0; k < 64; k++) begin
      col = sbox({x0[k], x1[k], x2[k], x3[k], x4[k]});
      {t0[k], t1[k], t2[k], t3[k], t4[k]} = col;
    end
    x0 = t0 ^ ror(t0, 19) ^ ror(t0, 28);
    x1 = t1 ^ ror(t1, 61) ^ ror(t1, 39);
    x2 = t2 ^ ror(t2, 1)  ^ ror(t2, 6);
    x3 = t3 ^ ror(t3, 10) ^ ror(t3, 17);
    x4 = t4 ^ ror(t4, 7)  ^ ror(t4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // UNROLL rounds chained in series starting at the current round index.
  always_comb begin
    logic [STATE_W-1:0] s;
    s = st_q;
    for (int u = 0; u < int'(UNROLL); u++) begin
      s = ascon_round(s, cnt_q + CNT_W'(u));
    end
    rnd_out = s;
  end

  assign legal_c = (rounds_i != 4'd0) && (rounds_i <= CNT_W'(MAX_ROUNDS)) &&
                   ((rounds_i & CNT_W'(UNROLL - 1)) == 4'd0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          if (legal_c) begin
            fsm_d   = RUN;
            st_d    = state_i;
            valid_d = 1'b0;
            cnt_d   = CNT_W'(MAX_ROUNDS) - rounds_i;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      RUN: begin
        st_d  = rnd_out;
        cnt_d = cnt_q + CNT_W'(UNROLL);
        // Terminal index MAX_ROUNDS ends the run before the counter can wrap.
        if (cnt_d == CNT_W'(MAX_ROUNDS)) begin
          fsm_d   = IDLE;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign state_o = st_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = done_q;
  assign valid_o = valid_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Bench for ascon_perm_core: three instances (UNROLL 1/2/4) checked against a
// table-driven word-array model of the ASCON permutation.
module tb_ascon_perm_core;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   start;
  logic [3:0]   rounds;
  logic [319:0] st_in;
  logic [319:0] st_o  [3];
  logic         busy  [3];
  logic         done  [3];
  logic         valid [3];
  logic         err   [3];
  logic [319:0] last_res [3];
  int           checks = 0;
  int           errors = 0;

  logic [4:0] sbox_tab [32] = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                                5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                                5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                                5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

  always #5 clk = ~clk;

  ascon_perm_core #(.UNROLL(1), .MAX_ROUNDS(12)) dut_u1 (
    .clock_i(clk), .reset_i(reset), .start_i(start[0]), .rounds_i(rounds), .state_i(st_in),
    .state_o(st_o[0]), .busy_o(busy[0]), .done_o(done[0]), .valid_o(valid[0]), .error_o(err[0]));
  ascon_perm_core #(.UNROLL(2), .MAX_ROUNDS(12)) dut_u2 (
    .clock_i(clk), .reset_i(reset), .start_i(start[1]), .rounds_i(rounds), .state_i(st_in),
    .state_o(st_o[1]), .busy_o(busy[1]), .done_o(done[1]), .valid_o(valid[1]), .error_o(err[1]));
  ascon_perm_core #(.UNROLL(4), .MAX_ROUNDS(12)) dut_u4 (
    .clock_i(clk), .reset_i(reset), .start_i(start[2]), .rounds_i(rounds), .state_i(st_in),
    .state_o(st_o[2]), .busy_o(busy[2]), .done_o(done[2]), .valid_o(valid[2]), .error_o(err[2]));

  function automatic int unroll_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference: five words, round index MAX-n+r, S-box applied column by column from the table.
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
    logic [63:0] x [5];
    logic [63:0] t [5];
    logic [4:0]  v, o;
    int          i;
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    for (int r = 0; r < n; r++) begin
      i = 12 - n + r;
      x[2][7:0] = x[2][7:0] ^ 8'((15 - i) * 16 + i);
      for (int k = 0; k < 64; k++) begin
        v = {x[0][k], x[1][k], x[2][k], x[3][k], x[4][k]};
        o = sbox_tab[v];
        for (int w = 0; w < 5; w++) x[w][k] = o[4 - w];
      end
      for (int w = 0; w < 5; w++) t[w] = x[w];
      x[0] = t[0] ^ rot(t[0], 19) ^ rot(t[0], 28);
      x[1] = t[1] ^ rot(t[1], 61) ^ rot(t[1], 39);
      x[2] = t[2] ^ rot(t[2], 1)  ^ rot(t[2], 6);
      x[3] = t[3] ^ rot(t[3], 10) ^ rot(t[3], 17);
      x[4] = t[4] ^ rot(t[4], 7)  ^ rot(t[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int j = 0; j < 10; j++) s[32*j +: 32] = $urandom;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch p^n on instance d and check load, busy window, done pulse, result and hold.
  task automatic run_perm(input int d, input logic [319:0] s, input int n);
    int           k;
    logic [319:0] exp;
    k   = n / unroll_of(d);
    exp = model_perm(s, n);
    start[d] = 1'b1;
    rounds   = 4'(n);
    st_in    = s;
    step();
    start[d] = 1'b0;
    st_in    = rand_state();
    checks++;
    if (busy[d] !== 1'b1 || st_o[d] !== s || valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL load d=%0d n=%0d: busy=%b valid=%b state=%h, need busy=1 valid=0 state=%h",
               d, n, busy[d], valid[d], st_o[d], s);
    end
    for (int c = 1; c <= k; c++) begin
      step();
      if (c < k) begin
        checks++;
        if (busy[d] !== 1'b1 || done[d] !== 1'b0) begin
          errors++;
          $display("FAIL running d=%0d n=%0d cycle %0d: busy=%b done=%b, need busy=1 done=0",
                   d, n, c, busy[d], done[d]);
        end
      end else begin
        checks++;
        if (busy[d] !== 1'b0 || done[d] !== 1'b1 || valid[d] !== 1'b1) begin
          errors++;
          $display("FAIL done d=%0d n=%0d cycle %0d: busy=%b done=%b valid=%b, need 0 1 1",
                   d, n, c, busy[d], done[d], valid[d]);
        end
        checks++;
        if (st_o[d] !== exp) begin
          errors++;
          $display("FAIL result d=%0d n=%0d: got %h need %h", d, n, st_o[d], exp);
        end
      end
    end
    step();
    checks++;
    if (done[d] !== 1'b0 || valid[d] !== 1'b1 || st_o[d] !== exp) begin
      errors++;
      $display("FAIL hold d=%0d n=%0d: done=%b valid=%b state=%h, need done=0 valid=1 state=%h",
               d, n, done[d], valid[d], st_o[d], exp);
    end
    last_res[d] = exp;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 3'b111;
    rounds = 4'd12;
    st_in  = rand_state();
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (st_o[d] !== 320'd0 || busy[d] !== 1'b0 || done[d] !== 1'b0 ||
          valid[d] !== 1'b0 || err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset d=%0d: state=%h busy=%b done=%b valid=%b error=%b, need all 0",
                 d, st_o[d], busy[d], done[d], valid[d], err[d]);
      end
    end
    reset = 1'b0;
    start = 3'b000;
    step();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy[d] !== 1'b0 || st_o[d] !== 320'd0) begin
        errors++;
        $display("FAIL reset_start d=%0d: busy=%b state=%h, need busy=0 state=0", d, busy[d], st_o[d]);
      end
    end
  endtask

  task automatic test_single_round();
    run_perm(0, 320'd0, 1);
    checks++;
    if (st_o[0][63:0] !== 64'd0) begin
      errors++;
      $display("FAIL single_x4: got %h need 0", st_o[0][63:0]);
    end
  endtask

  task automatic test_full();
    for (int d = 0; d < 3; d++) begin
      for (int rep = 0; rep < 2; rep++) begin
        run_perm(d, rand_state(), 12);
        run_perm(d, rand_state(), 8);
      end
    end
  endtask

  task automatic test_illegal();
    int bad [$];
    for (int d = 0; d < 3; d++) begin
      run_perm(d, rand_state(), 12);
      bad = '{0, 13, 15};
      if (d >= 1) begin
        bad.push_back(1);
        bad.push_back(3);
      end
      if (d == 2) bad.push_back(6);
      foreach (bad[j]) begin
        start[d] = 1'b1;
        rounds   = 4'(bad[j]);
        st_in    = rand_state();
        step();
        start[d] = 1'b0;
        checks++;
        if (err[d] !== 1'b1 || busy[d] !== 1'b0 || valid[d] !== 1'b1 || st_o[d] !== last_res[d]) begin
          errors++;
          $display("FAIL illegal d=%0d n=%0d: error=%b busy=%b valid=%b state=%h, need 1 0 1 %h",
                   d, bad[j], err[d], busy[d], valid[d], st_o[d], last_res[d]);
        end
        step();
        checks++;
        if (err[d] !== 1'b0 || busy[d] !== 1'b0 || valid[d] !== 1'b1 || st_o[d] !== last_res[d]) begin
          errors++;
          $display("FAIL illegal_after d=%0d n=%0d: error=%b busy=%b valid=%b, need 0 0 1",
                   d, bad[j], err[d], busy[d], valid[d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [319:0] s1, s2, e1, e2;
    s1 = rand_state();
    s2 = rand_state();
    e1 = model_perm(s1, 8);
    e2 = model_perm(s2, 8);
    start[1] = 1'b1;
    rounds   = 4'd8;
    st_in    = s1;
    step();
    st_in = s2;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (err[1] !== 1'b0) begin
        errors++;
        $display("FAIL busy_start_err cycle %0d: error=%b need 0", c, err[1]);
      end
    end
    checks++;
    if (done[1] !== 1'b1 || st_o[1] !== e1) begin
      errors++;
      $display("FAIL b2b_first: done=%b state=%h, need done=1 state=%h", done[1], st_o[1], e1);
    end
    step();
    start[1] = 1'b0;
    checks++;
    if (busy[1] !== 1'b1 || done[1] !== 1'b0 || st_o[1] !== s2) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b state=%h, need 1 0 %h", busy[1], done[1], st_o[1], s2);
    end
    for (int c = 1; c <= 4; c++) step();
    checks++;
    if (done[1] !== 1'b1 || valid[1] !== 1'b1 || st_o[1] !== e2) begin
      errors++;
      $display("FAIL b2b_second: done=%b valid=%b state=%h, need 1 1 %h", done[1], valid[1], st_o[1], e2);
    end
    step();
  endtask

  task automatic test_reset_mid();
    start[0] = 1'b1;
    rounds   = 4'd12;
    st_in    = rand_state();
    step();
    start[0] = 1'b0;
    for (int c = 0; c < 3; c++) step();
    reset = 1'b1;
    step();
    checks++;
    if (st_o[0] !== 320'd0 || busy[0] !== 1'b0 || done[0] !== 1'b0 ||
        valid[0] !== 1'b0 || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: state=%h busy=%b done=%b valid=%b error=%b, need all 0",
               st_o[0], busy[0], done[0], valid[0], err[0]);
    end
    reset = 1'b0;
    step();
    run_perm(0, rand_state(), 8);
    run_perm(2, rand_state(), 8);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 3'b000;
    rounds = 4'd0;
    st_in  = '0;
    test_reset();
    test_single_round();
    test_full();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_perm_core.md
# ascon_perm_core

Iterative, parametrised ASCON permutation engine that applies p^n (n = 1..12 rounds) to a 320-bit state. UNROLL rounds execute per clock. The block sits between the AEAD mode FSM and the state register file. It replaces the fixed p^a/p^b round logic with a single core that is programmable per call, and it adds a start/done handshake and argument checking.

## Interface
- UNROLL, 1, rounds per clock; legal values 1, 2, 4.
- MAX_ROUNDS, 12, maximum round count; round-constant indexing is relative to this value.
- clock_i  in  1  system clock; all logic on its rising edge.
- reset_i  in  1  reset, synchronous and active-high.
- start_i  in  1  request a permutation; sampled only when busy_o=0.
- rounds_i  in  4  number of rounds n; sampled with start_i.
- state_i  in  320  input state; x0=state_i[319:256] … x4=state_i[63:0].
- state_o  out  320  state register, same word order as state_i.
- busy_o  out  1  permutation in progress.
- done_o  out  1  one-cycle pulse when the result is present on state_o.
- valid_o  out  1  state_o holds a completed result; cleared by the next accepted start.
- error_o  out  1  one-cycle pulse when a start is rejected.

## Operation
- Round r, with index i = MAX_ROUNDS − n + r for r = 0..n−1:
  - Constant addition: x2[7:0] ^= c_i, where c_i = {4'(15−i), 4'(i)}. This gives F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B.
  - Substitution: each of the 64 bit columns forms the 5-bit value {x0[k],x1[k],x2[k],x3[k],x4[k]} (x0 = MSB). The value is replaced via the table 04,0B,1F,14,1A,15,09,02,1B,05,08,12,1D,03,06,1C,1E,13,07,0E,00,0D,11,18,10,0C,01,19,16,0A,0F,17.
  - Linear layer (ror = rotate right): x0^=ror19^ror28, x1^=ror61^ror39, x2^=ror1^ror6, x3^=ror10^ror17, x4^=ror7^ror41. Each rotation is of the word's own pre-layer value.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1; a round counter holds the current index i.
  - IDLE→RUN when start_i=1 and rounds_i is legal.
  - RUN→IDLE after the final group of UNROLL rounds.
- Legal rounds_i: 1 ≤ n ≤ MAX_ROUNDS and n mod UNROLL = 0.
  - Illegal start: error_o pulses, the FSM stays in IDLE, and state_o and valid_o are unchanged.
- Accepted start: state_o is loaded with state_i, valid_o clears, and the counter is set to MAX_ROUNDS − n.
- Each RUN cycle: UNROLL rounds are applied combinationally in series and the counter advances by UNROLL.
  - The counter is 4 bits; it never wraps because the terminal value MAX_ROUNDS ends RUN.
- start_i is ignored while busy_o=1. This is not an error and produces no pulse.
- The result is held on state_o with valid_o=1 indefinitely until the next accepted start or reset.

## Timing
- Reset values: state_o=0, busy_o=0, done_o=0, valid_o=0, error_o=0, FSM=IDLE, counter=0.
- Reset during RUN: the permutation is abandoned and all outputs take their reset values on the next edge.
- Edge E0 samples start_i with a legal n:
  - After E0: busy_o=1 and state_o=state_i.
  - Edges E1..Ek, with k = n/UNROLL, each apply UNROLL rounds. state_o shows intermediate states during RUN and must not be consumed.
  - After Ek: busy_o=0, done_o=1 for exactly one cycle, valid_o=1, and state_o holds the final state.
  - Latency from start sample to done: k cycles. Back-to-back starts can be sampled at Ek+1, which gives a throughput of one permutation per k+1 cycles.
- Illegal start sampled at E0: error_o=1 in the cycle after E0 only.
- Reset and start asserted together: reset wins.

## Test plan
- Reset check: assert reset_i for 2 cycles → all outputs 0; start_i held high during reset is not accepted.
- Single round, UNROLL=1: state_i=0, n=1 → done after 1 cycle. state_o matches the golden model (constant 4B). x4=0 and x0, x1, x3 equal each other's model values.
- Full p^12 and p^8 on random states with UNROLL=1, 2, 4 → bit-exact match with the software model. done_o appears at cycles 12/6/3 and 8/4/2 respectively.
- Illegal arguments: n=0, n=13, and n=6 with UNROLL=4 → error_o single pulse, busy_o stays 0, and the previous valid result is kept.
- Start during busy: a second start_i with different data while busy → ignored, and the first result is correct. A start held high continuously gives back-to-back permutations with a one-cycle IDLE gap.
- Reset mid-run: reset_i asserted at cycle 3 of p^12 → outputs go to 0. A following p^8 runs correctly.
